dac_sample_fifo: RTL and testbench

- Buffers PCM codes from an upstream producer (tone generator, UART loader, ROM sequencer) in a synchronous FIFO.
- Presents one stable code per PWM window to the downstream PWM DAC.
- Advances to the next sample only when the DAC pulses next_sample. Holds the last code on underrun and counts the underruns.

---
 rtl/dac_sample_fifo.sv | 83 ++++++++
 tb/tb_dac_sample_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_fifo.sv
// Sample FIFO between a PCM producer and a PWM DAC: one registered code per
// DAC window, advanced on next_sample, held (and counted) on underrun.
module dac_sample_fifo #(
  parameter int CODE_WIDTH     = 10,
  parameter int DEPTH          = 16,
  parameter int CNT_WIDTH      = $clog2(DEPTH) + 1,
  parameter int UNDERRUN_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CODE_WIDTH-1:0]     in_code,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      next_sample,
  output logic [CODE_WIDTH-1:0]     code,
  output logic [CNT_WIDTH-1:0]      level,
  output logic                      empty,
  output logic                      full,
  output logic [UNDERRUN_WIDTH-1:0] underrun_cnt,
  input  logic                      clr_underrun
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [UNDERRUN_WIDTH-1:0] UR_ONE = UNDERRUN_WIDTH'(1);

  logic [CODE_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic                  push;
  logic                  pop;
  logic                  underrun;

  // Status derives from registered level only, so in_ready never sees next_sample.
  assign full     = (level == CNT_WIDTH'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !full;

  assign push     = in_valid && in_ready;
  assign pop      = next_sample && !empty;
  assign underrun = next_sample && empty;

  // Storage carries no reset; contents are meaningless while level is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      code  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        code <= mem[rptr];
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + CNT_ONE;
        2'b01:   level <= level - CNT_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (clr_underrun) begin
      underrun_cnt <= '0;
    end else if (underrun && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + UR_ONE;
    end
  end

endmodule

// File: tb/tb_dac_sample_fifo.sv
// Scenario bench for dac_sample_fifo against a queue-based reference model.
module tb_dac_sample_fifo;

  localparam int CODE_WIDTH     = 10;
  localparam int DEPTH          = 16;
  localparam int CNT_WIDTH      = 5;
  localparam int UNDERRUN_WIDTH = 8;
  localparam int UR_MAX         = 255;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [CODE_WIDTH-1:0]     in_code = '0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      next_sample = 1'b0;
  logic [CODE_WIDTH-1:0]     code;
  logic [CNT_WIDTH-1:0]      level;
  logic                      empty;
  logic                      full;
  logic [UNDERRUN_WIDTH-1:0] underrun_cnt;
  logic                      clr_underrun = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int q[$];
  int m_code = 0;
  int m_ur   = 0;
  bit last_acc;
  bit last_pop;

  dac_sample_fifo #(
    .CODE_WIDTH(CODE_WIDTH),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CNT_WIDTH),
    .UNDERRUN_WIDTH(UNDERRUN_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_code(in_code),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .next_sample(next_sample),
    .code(code),
    .level(level),
    .empty(empty),
    .full(full),
    .underrun_cnt(underrun_cnt),
    .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model advances from the pre-edge state.
  task automatic cycle(input bit v, input int d, input bit ns, input bit clr);
    in_valid     = v;
    in_code      = CODE_WIDTH'(d);
    next_sample  = ns;
    clr_underrun = clr;
    @(posedge clk);
    last_acc = v && (q.size() < DEPTH);
    last_pop = ns && (q.size() > 0);
    if (last_pop) m_code = q.pop_front();
    if (clr) m_ur = 0;
    else if (ns && !last_pop && m_ur < UR_MAX) m_ur++;
    if (last_acc) q.push_back(d);
    #1;
    in_valid     = 1'b0;
    next_sample  = 1'b0;
    clr_underrun = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_code = 0;
    m_ur   = 0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (level !== '0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
    n_checks++; if (code !== '0) $display("FAIL reset_code got %0d want 0", code); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (underrun_cnt !== '0) $display("FAIL reset_underrun got %0d want 0", underrun_cnt); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    cycle(1, 3, 0, 0);
    cycle(1, 700, 0, 0);
    cycle(1, 1023, 0, 0);
    n_checks++; if (level !== 5'd3) $display("FAIL basic_level got %0d want 3", level); else n_pass++;
    n_checks++; if (code !== 10'd0) $display("FAIL basic_code_idle got %0d want 0", code); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready got %b want 1", in_ready); else n_pass++;
    cycle(0, 0, 1, 0);
    n_checks++; if (code !== 10'd3) $display("FAIL basic_first_pop got %0d want 3", code); else n_pass++;
    n_checks++; if (level !== 5'd2) $display("FAIL basic_level_pop got %0d want 2", level); else n_pass++;
    cycle(0, 0, 1, 0);
    n_checks++; if (code !== CODE_WIDTH'(m_code)) $display("FAIL basic_second_pop got %0d want %0d", code, m_code); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, i, 0, 0);
    n_checks++; if (full !== 1'b1) $display("FAIL full_flag got %b want 1", full); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else n_pass++;
    cycle(1, 999, 0, 0);
    n_checks++; if (level !== CNT_WIDTH'(DEPTH)) $display("FAIL full_no_write got %0d want %0d", level, DEPTH); else n_pass++;
    cycle(1, 999, 1, 0);
    n_checks++; if (code !== 10'd0) $display("FAIL full_pop_code got %0d want 0", code); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL full_pop_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (level !== 5'd15) $display("FAIL full_pop_only got %0d want 15", level); else n_pass++;
    cycle(1, 999, 0, 0);
    n_checks++; if (full !== 1'b1) $display("FAIL full_accept_999 got %b want 1", full); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, 0);
      n_checks++; if (code !== CODE_WIDTH'(m_code)) $display("FAIL full_drain got %0d want %0d", code, m_code); else n_pass++;
    end
    n_checks++; if (code !== 10'd999) $display("FAIL full_last got %0d want 999", code); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL full_drained_empty got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_underrun();
    do_reset();
    cycle(1, 42, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
    n_checks++; if (code !== 10'd42) $display("FAIL ur_hold got %0d want 42", code); else n_pass++;
    n_checks++; if (underrun_cnt !== 8'd3) $display("FAIL ur_count got %0d want 3", underrun_cnt); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL ur_level got %0d want 0", level); else n_pass++;
    cycle(0, 0, 1, 1);
    n_checks++; if (underrun_cnt !== 8'd0) $display("FAIL ur_clr_priority got %0d want 0", underrun_cnt); else n_pass++;
    for (int i = 0; i < 300; i++) cycle(0, 0, 1, 0);
    n_checks++; if (underrun_cnt !== 8'd255) $display("FAIL ur_saturate got %0d want 255", underrun_cnt); else n_pass++;
    n_checks++; if (underrun_cnt !== UNDERRUN_WIDTH'(m_ur)) $display("FAIL ur_model got %0d want %0d", underrun_cnt, m_ur); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1, 100, 0, 0);
    cycle(1, 200, 1, 0);
    n_checks++; if (code !== 10'd100) $display("FAIL b2b_code got %0d want 100", code); else n_pass++;
    n_checks++; if (level !== 5'd1) $display("FAIL b2b_level got %0d want 1", level); else n_pass++;
    cycle(0, 0, 1, 0);
    n_checks++; if (code !== 10'd200) $display("FAIL b2b_next got %0d want 200", code); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL b2b_empty got %0d want 0", level); else n_pass++;
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    cycle(1, 55, 1, 0);
    n_checks++; if (underrun_cnt !== 8'd1) $display("FAIL epp_underrun got %0d want 1", underrun_cnt); else n_pass++;
    n_checks++; if (code !== 10'd0) $display("FAIL epp_no_bypass got %0d want 0", code); else n_pass++;
    n_checks++; if (level !== 5'd1) $display("FAIL epp_level got %0d want 1", level); else n_pass++;
    cycle(0, 0, 1, 0);
    n_checks++; if (code !== 10'd55) $display("FAIL epp_pop got %0d want 55", code); else n_pass++;
  endtask

  task automatic test_stream();
    int exp_vals[40];
    int sent   = 0;
    int popped = 0;
    int pend;
    do_reset();
    pend = $urandom_range(1, 1023);
    for (int c = 0; c < 1000 && popped < 40; c++) begin
      cycle(sent < 40, pend, (c % 4) == 3, 0);
      if (last_acc) begin
        exp_vals[sent] = pend;
        sent++;
        pend = $urandom_range(1, 1023);
      end
      if (last_pop) begin
        n_checks++; if (code !== CODE_WIDTH'(exp_vals[popped])) $display("FAIL stream_order idx %0d got %0d want %0d", popped, code, exp_vals[popped]); else n_pass++;
        popped++;
      end
      n_checks++; if (level !== CNT_WIDTH'(q.size())) $display("FAIL stream_level got %0d want %0d", level, q.size()); else n_pass++;
    end
    n_checks++; if (popped != 40) $display("FAIL stream_timeout popped %0d want 40", popped); else n_pass++;
    n_checks++; if (underrun_cnt !== 8'd0) $display("FAIL stream_no_underrun got %0d want 0", underrun_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int pend;
    do_reset();
    pend = $urandom_range(0, 1023);
    for (int c = 0; c < 300; c++) begin
      cycle($urandom_range(0, 1) == 1, pend, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      if (last_acc) pend = $urandom_range(0, 1023);
      n_checks++; if (code !== CODE_WIDTH'(m_code)) $display("FAIL rand_code got %0d want %0d", code, m_code); else n_pass++;
      n_checks++; if (level !== CNT_WIDTH'(q.size())) $display("FAIL rand_level got %0d want %0d", level, q.size()); else n_pass++;
      n_checks++; if (empty !== (q.size() == 0)) $display("FAIL rand_empty got %b want %b", empty, q.size() == 0); else n_pass++;
      n_checks++; if (full !== (q.size() == DEPTH)) $display("FAIL rand_full got %b want %b", full, q.size() == DEPTH); else n_pass++;
      n_checks++; if (in_ready !== (q.size() != DEPTH)) $display("FAIL rand_in_ready got %b want %b", in_ready, q.size() != DEPTH); else n_pass++;
      n_checks++; if (underrun_cnt !== UNDERRUN_WIDTH'(m_ur)) $display("FAIL rand_underrun got %0d want %0d", underrun_cnt, m_ur); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 500 + i, 0, 0);
    cycle(0, 0, 1, 0);
    n_checks++; if (code !== 10'd500) $display("FAIL midrst_pre_code got %0d want 500", code); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (code !== 10'd0) $display("FAIL midrst_code got %0d want 0", code); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL midrst_level got %0d want 0", level); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL midrst_empty got %b want 1", empty); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    m_code = 0;
    m_ur   = 0;
    cycle(0, 0, 1, 0);
    n_checks++; if (underrun_cnt !== 8'd1) $display("FAIL midrst_discarded got %0d want 1", underrun_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underrun();
    test_back_to_back();
    test_empty_push_pop();
    test_stream();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
